sprite_row_renderer: RTL

- Downstream consumer of the video sync generator's hpos/vpos/display_on beam position.
- Renders one 1-bit, SPRITE_W-pixel-wide, 2^ROW_BITS-line-tall sprite at a programmable (sprite_x, sprite_y).
- During each line's horizontal blank it fetches the sprite row needed for the next line from an external synchronous bitmap ROM.
- It then shifts that row out as a pixel stream, gfx, when the beam reaches sprite_x on the following line.

---
 rtl/sprite_row_renderer_if.sv | 28 ++
 rtl/sprite_row_renderer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_row_renderer_if.sv
// ---------------------------------------------------------------------------
// sprite_row_renderer_if
//   ROM bus between the sprite row renderer and its synchronous bitmap ROM.
//
//   rom_addr : sprite row address, driven by the renderer (registered)
//   rom_data : row bits returned by the ROM one clk after rom_addr changes,
//              MSB is the leftmost pixel
//
//   master : renderer side (drives rom_addr, reads rom_data)
//   slave  : ROM side      (reads rom_addr, drives rom_data)
// ---------------------------------------------------------------------------
interface sprite_row_renderer_if #(
    parameter int ROW_BITS = 4,
    parameter int SPRITE_W = 8
);
    logic [ROW_BITS-1:0] rom_addr;
    logic [SPRITE_W-1:0] rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/sprite_row_renderer.sv
// ---------------------------------------------------------------------------
// sprite_row_renderer
//   Draws one 1-bit sprite (SPRITE_W wide, 2^ROW_BITS lines tall) at a
//   programmable (sprite_x, sprite_y) on top of the sync generator's beam.
//   In each line's horizontal blank the row needed for the NEXT line is
//   fetched from an external synchronous ROM, then shifted out MSB first on
//   gfx when the beam reaches sprite_x. gfx lags the beam by one clock, so
//   pixel k is on gfx while hpos == sprite_x + 1 + k.
//
// Ports
//   clk        : pixel clock (shared with the sync generator)
//   reset      : asynchronous, active-high
//   hpos, vpos : beam position
//   display_on : visible-area flag; pixels emitted outside it read as 0
//   enable     : sprite enable, sampled at the fetch point only
//   sprite_x   : left column, sampled while waiting to draw
//   sprite_y   : top line, sampled at the fetch point only
//   rom        : ROM bus (master side), rom_addr registered
//   gfx        : sprite pixel (registered)
//   busy       : high whenever the FSM is not idle
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | nothing pending; waiting for a fetch point with row in range
//   FETCH   | rom_addr just loaded; ROM needs one clk to respond
//   LATCH   | rom_data valid; captured into the shift register
//   WAIT_H  | row held; waiting for hpos == sprite_x on the next line
//   DRAW    | shifting the row out on gfx, one pixel per clk
// ---------------------------------------------------------------------------
module sprite_row_renderer #(
    parameter int H_DISPLAY = 256,
    parameter int V_MAX     = 261,
    parameter int SPRITE_W  = 8,
    parameter int ROW_BITS  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8:0]             hpos,
    input  logic [8:0]             vpos,
    input  logic                   display_on,
    input  logic                   enable,
    input  logic [8:0]             sprite_x,
    input  logic [8:0]             sprite_y,
    sprite_row_renderer_if.master  rom,
    output logic                   gfx,
    output logic                   busy
);

    localparam int                CNT_W    = $clog2(SPRITE_W + 1);
    localparam logic [8:0]        H_FETCH  = 9'(H_DISPLAY);
    localparam logic [8:0]        V_LAST   = 9'(V_MAX);
    localparam logic [9:0]        ROWS     = 10'(1 << ROW_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPRITE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT_H,
        S_DRAW
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ROW_BITS-1:0] rom_addr_q;
    logic [SPRITE_W-1:0] shift_q;
    logic [CNT_W-1:0]    count_q;
    logic                gfx_q;

    logic [8:0] next_v;
    logic [9:0] row;
    logic       in_range;
    logic       fetch_pt;
    logic       fetch_go;
    logic       draw_go;
    logic       draw_end;

    logic       ld_addr;
    logic       ld_shift;
    logic       pix_start;
    logic       pix_next;
    logic       gfx_clr;

    // Row selection is for the line after the current one, wrapping at V_MAX.
    // The 10-bit difference makes lines above sprite_y land far out of range
    // instead of aliasing onto a valid row.
    assign next_v   = (vpos == V_LAST) ? 9'd0 : vpos + 9'd1;
    assign row      = {1'b0, next_v} - {1'b0, sprite_y};
    assign in_range = row < ROWS;
    assign fetch_pt = (hpos == H_FETCH);
    assign fetch_go = fetch_pt && enable && in_range;
    // A sprite_x in the blank region never starts a draw; the next fetch
    // point retires the row instead.
    assign draw_go  = (hpos == sprite_x) && (sprite_x < H_FETCH);
    assign draw_end = (count_q == CNT_LAST);

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_go) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                state_nxt = S_WAIT_H;
            end
            S_WAIT_H: begin
                // The fetch point wins over a pending draw start.
                if (fetch_pt) begin
                    state_nxt = fetch_go ? S_FETCH : S_IDLE;
                end else if (draw_go) begin
                    state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                // A row clipped at the right edge is cut short here.
                if (fetch_pt) begin
                    state_nxt = fetch_go ? S_FETCH : S_IDLE;
                end else if (draw_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // Output / datapath control decode
    // -----------------------------------------------------------------
    always_comb begin
        ld_addr   = 1'b0;
        ld_shift  = 1'b0;
        pix_start = 1'b0;
        pix_next  = 1'b0;
        gfx_clr   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                ld_addr = fetch_go;
            end
            S_FETCH: begin
            end
            S_LATCH: begin
                ld_shift = 1'b1;
            end
            S_WAIT_H: begin
                if (fetch_pt) begin
                    gfx_clr = 1'b1;
                    ld_addr = fetch_go;
                end else if (draw_go) begin
                    pix_start = 1'b1;
                end
            end
            S_DRAW: begin
                if (fetch_pt) begin
                    gfx_clr = 1'b1;
                    ld_addr = fetch_go;
                end else if (draw_end) begin
                    gfx_clr = 1'b1;
                end else begin
                    pix_next = 1'b1;
                end
            end
            default: begin
                gfx_clr = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_q <= '0;
            shift_q    <= '0;
            count_q    <= '0;
            gfx_q      <= 1'b0;
        end else begin
            if (ld_addr) begin
                rom_addr_q <= row[ROW_BITS-1:0];
            end

            if (ld_shift) begin
                shift_q <= rom.rom_data;
            end else if (pix_start || pix_next) begin
                shift_q <= {shift_q[SPRITE_W-2:0], 1'b0};
            end

            if (pix_start) begin
                count_q <= CNT_W'(1);
            end else if (pix_next) begin
                count_q <= count_q + CNT_W'(1);
            end

            // Clipped pixels are dropped, never postponed.
            if (pix_start || pix_next) begin
                gfx_q <= shift_q[SPRITE_W-1] & display_on;
            end else if (gfx_clr) begin
                gfx_q <= 1'b0;
            end
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign gfx          = gfx_q;

endmodule
